// File: rtl/sys_defs.sv
// Shared system definitions for the memory-side blocks.
// Provides the bus command encoding, address width, tag geometry and the
// tag-table entry type used by mem_arbiter_n.
package sys_defs;

  localparam int XLEN       = 32;
  localparam int TAG_W      = 4;
  localparam int NUM_TAGS   = 15;  // tag 0 means "no tag", so 1..15 usable
  localparam int TAG_PORT_W = 4;   // room for up to 16 requesting ports

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic                  valid;
    logic [TAG_PORT_W-1:0] port;
  } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_arbiter_n_rr_arbiter.sv
// rr_arbiter: picks one requester per cycle, one-hot grant.
// Build option MEM_ARBITER_RR_EN:
//   defined   -> round-robin; search starts at ptr, ptr moves to one past
//                the granted port when `advance` pulses.
//   undefined -> fixed priority, lowest index wins.
// Ports:
//   clock, reset   : system clock, synchronous active-low reset
//   req[N]         : request vector
//   advance        : grant was consumed this cycle
//   grant[N]       : one-hot grant (zero when no request)
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  // Circular search starting at ptr_q; with fixed priority ptr_q stays 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

`ifdef MEM_ARBITER_RR_EN
  int gidx;

  always_comb begin
    gidx = 0;
    for (int i = 0; i < N; i++)
      if (grant[i]) gidx = i;
    ptr_d = advance ? IW'((gidx + 1) % N) : ptr_q;
  end
`else
  // Fixed priority: search origin is pinned at port 0.
  always_comb ptr_d = advance ? '0 : ptr_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: shares one memory bus between NUM_PORTS caches.
// Arbitrates requests each cycle, tracks in-flight loads in a 15-entry tag
// table and routes memory responses back to the issuing port.
// Build option MEM_ARBITER_RR_EN selects round-robin (else fixed priority).
// Ports:
//   clock, reset                      : clock, synchronous active-low reset
//   port_command/addr/data            : per-port request
//   port_accept, port_accept_tag      : combinational acceptance + tag
//   proc2mem_command/addr/data        : request to memory
//   mem2proc_response/data/tag        : memory acceptance tag / return
//   resp_valid/port/data/tag          : registered routed response
//   outstanding_count, err_unknown_tag: occupancy, stray-tag pulse
module mem_arbiter_n
  import sys_defs::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  BUS_COMMAND [NUM_PORTS-1:0]                port_command,
  input  logic [NUM_PORTS-1:0][XLEN-1:0]            port_addr,
  input  logic [NUM_PORTS-1:0][63:0]                port_data,
  output logic [NUM_PORTS-1:0]                      port_accept,
  output logic [3:0]                                port_accept_tag,
  output BUS_COMMAND                                proc2mem_command,
  output logic [XLEN-1:0]                           proc2mem_addr,
  output logic [63:0]                               proc2mem_data,
  input  logic [3:0]                                mem2proc_response,
  input  logic [63:0]                               mem2proc_data,
  input  logic [3:0]                                mem2proc_tag,
  output logic                                      resp_valid,
  output logic [(NUM_PORTS>1?$clog2(NUM_PORTS):1)-1:0] resp_port,
  output logic [63:0]                               resp_data,
  output logic [3:0]                                resp_tag,
  output logic [3:0]                                outstanding_count,
  output logic                                      err_unknown_tag
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] req, grant;
  logic [PW-1:0]        gsel;
  logic                 full, accepted, alloc, hit, unknown;
  MEM_TAG_ENTRY         ret_entry;

  MEM_TAG_ENTRY tbl_q [1:NUM_TAGS];
  MEM_TAG_ENTRY tbl_d [1:NUM_TAGS];
  logic [3:0]   count_q, count_d;

  logic         resp_valid_q, err_q;
  logic [PW-1:0] resp_port_q;
  logic [63:0]  resp_data_q;
  logic [3:0]   resp_tag_q;

  assign full = (count_q >= 4'(MAX_OUTSTANDING));

  // Requests are masked while full or in reset so nothing reaches memory.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      req[i] = reset && !full && (port_command[i] != BUS_NONE);
  end

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (accepted),
    .grant   (grant)
  );

  always_comb begin
    gsel = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant[i]) gsel = PW'(i);
  end

  assign proc2mem_command = (|grant) ? port_command[gsel] : BUS_NONE;
  assign proc2mem_addr    = port_addr[gsel];
  assign proc2mem_data    = port_data[gsel];

  // Memory accepts by returning a nonzero tag in the issuing cycle.
  assign accepted        = (|grant) && (mem2proc_response != 4'd0);
  assign alloc           = accepted && (proc2mem_command == BUS_LOAD);
  assign port_accept     = accepted ? grant : '0;
  assign port_accept_tag = accepted ? mem2proc_response : 4'd0;

  assign ret_entry = (mem2proc_tag != 4'd0) ? tbl_q[mem2proc_tag] : '0;
  assign hit       = (mem2proc_tag != 4'd0) && ret_entry.valid;
  assign unknown   = (mem2proc_tag != 4'd0) && !ret_entry.valid;

  // Free is applied before allocate so a tag recycled in the same cycle
  // ends up owned by the new requester.
  always_comb begin
    tbl_d = tbl_q;
    if (hit)   tbl_d[mem2proc_tag].valid = 1'b0;
    if (alloc) tbl_d[mem2proc_response]  = '{valid: 1'b1, port: TAG_PORT_W'(gsel)};
    count_d = count_q + {3'b0, alloc} - {3'b0, hit};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int t = 1; t <= NUM_TAGS; t++) tbl_q[t] <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_port_q  <= '0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      tbl_q        <= tbl_d;
      count_q      <= count_d;
      resp_valid_q <= hit;
      resp_port_q  <= hit ? PW'(ret_entry.port) : '0;
      resp_data_q  <= hit ? mem2proc_data : '0;
      resp_tag_q   <= hit ? mem2proc_tag : 4'd0;
      err_q        <= unknown;
    end
  end

  assign resp_valid        = resp_valid_q;
  assign resp_port         = resp_port_q;
  assign resp_data         = resp_data_q;
  assign resp_tag          = resp_tag_q;
  assign outstanding_count = count_q;
  assign err_unknown_tag   = err_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
module tb_mem_arbiter_n;
  import sys_defs::*;

  logic                  clock = 1'b0;
  logic                  reset;
  BUS_COMMAND [1:0]      port_command;
  logic [1:0][XLEN-1:0]  port_addr;
  logic [1:0][63:0]      port_data;
  logic [1:0]            port_accept;
  logic [3:0]            port_accept_tag;
  BUS_COMMAND            proc2mem_command;
  logic [XLEN-1:0]       proc2mem_addr;
  logic [63:0]           proc2mem_data;
  logic [3:0]            mem2proc_response;
  logic [63:0]           mem2proc_data;
  logic [3:0]            mem2proc_tag;
  logic                  resp_valid;
  logic [0:0]            resp_port;
  logic [63:0]           resp_data;
  logic [3:0]            resp_tag;
  logic [3:0]            outstanding_count;
  logic                  err_unknown_tag;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mem_arbiter_n #(.NUM_PORTS(2), .MAX_OUTSTANDING(2)) dut (
    .clock(clock), .reset(reset),
    .port_command(port_command), .port_addr(port_addr), .port_data(port_data),
    .port_accept(port_accept), .port_accept_tag(port_accept_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .resp_valid(resp_valid), .resp_port(resp_port), .resp_data(resp_data), .resp_tag(resp_tag),
    .outstanding_count(outstanding_count), .err_unknown_tag(err_unknown_tag)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input BUS_COMMAND c0, input BUS_COMMAND c1,
                       input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] d);
    port_command[0]   = c0;
    port_command[1]   = c1;
    mem2proc_response = rsp;
    mem2proc_tag      = tg;
    mem2proc_data     = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(BUS_LOAD, BUS_NONE, 4'd3, 4'd0, 64'h0);
    #1;
    tests++; if (proc2mem_command !== BUS_NONE) begin fails++; $display("FAIL rst_cmd: got %0d want %0d", proc2mem_command, BUS_NONE); end
    tests++; if (port_accept !== 2'b00) begin fails++; $display("FAIL rst_accept: got %0b want 00", port_accept); end
    tick();
    tests++; if (outstanding_count !== 4'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", outstanding_count); end
    tests++; if (resp_valid !== 1'b0 || resp_tag !== 4'd0 || err_unknown_tag !== 1'b0) begin fails++; $display("FAIL rst_resp: got v=%0b t=%0d e=%0b want 0 0 0", resp_valid, resp_tag, err_unknown_tag); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd0, 64'h0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_two_loads();
    drive(BUS_LOAD, BUS_LOAD, 4'd1, 4'd0, 64'h0);
    #1;
    tests++; if (port_accept !== 2'b01 || port_accept_tag !== 4'd1) begin fails++; $display("FAIL two_first: got acc=%0b tag=%0d want 01 1", port_accept, port_accept_tag); end
    tests++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 32'h1000) begin fails++; $display("FAIL two_first_bus: got cmd=%0d addr=%0h want 1 1000", proc2mem_command, proc2mem_addr); end
    tick();
    drive(BUS_NONE, BUS_LOAD, 4'd2, 4'd0, 64'h0);
    #1;
    tests++; if (port_accept !== 2'b10 || port_accept_tag !== 4'd2 || proc2mem_addr !== 32'h2000) begin fails++; $display("FAIL two_second: got acc=%0b tag=%0d addr=%0h want 10 2 2000", port_accept, port_accept_tag, proc2mem_addr); end
    tick();
    tests++; if (outstanding_count !== 4'd2) begin fails++; $display("FAIL two_count: got %0d want 2", outstanding_count); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd2, 64'hAAAA);
    tick();
    tests++; if (resp_valid !== 1'b1 || resp_port !== 1'b1 || resp_tag !== 4'd2 || resp_data !== 64'hAAAA) begin fails++; $display("FAIL two_resp2: got v=%0b p=%0d t=%0d d=%0h want 1 1 2 aaaa", resp_valid, resp_port, resp_tag, resp_data); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd1, 64'hBBBB);
    tick();
    tests++; if (resp_valid !== 1'b1 || resp_port !== 1'b0 || resp_tag !== 4'd1 || resp_data !== 64'hBBBB) begin fails++; $display("FAIL two_resp1: got v=%0b p=%0d t=%0d d=%0h want 1 0 1 bbbb", resp_valid, resp_port, resp_tag, resp_data); end
    tests++; if (outstanding_count !== 4'd0) begin fails++; $display("FAIL two_count_end: got %0d want 0", outstanding_count); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd0, 64'h0);
    tick();
    tests++; if (resp_valid !== 1'b0 || resp_tag !== 4'd0) begin fails++; $display("FAIL two_idle: got v=%0b t=%0d want 0 0", resp_valid, resp_tag); end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp;
    for (int n = 0; n < 6; n++) begin
`ifdef MEM_ARBITER_RR_EN
      exp = (n % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp = 2'b01;
`endif
      drive(BUS_STORE, BUS_STORE, 4'd4, 4'd0, 64'h0);
      #1;
      tests++; if (port_accept !== exp) begin fails++; $display("FAIL arb_grant%0d: got %0b want %0b", n, port_accept, exp); end
      tick();
    end
    tests++; if (outstanding_count !== 4'd0) begin fails++; $display("FAIL arb_store_count: got %0d want 0", outstanding_count); end
  endtask

  task automatic test_refused();
    drive(BUS_STORE, BUS_STORE, 4'd0, 4'd0, 64'h0);
    #1;
    tests++; if (port_accept !== 2'b00 || proc2mem_command !== BUS_STORE) begin fails++; $display("FAIL refused: got acc=%0b cmd=%0d want 00 2", port_accept, proc2mem_command); end
    tick();
    drive(BUS_STORE, BUS_STORE, 4'd4, 4'd0, 64'h0);
    #1;
    tests++; if (port_accept !== 2'b01) begin fails++; $display("FAIL refused_retry: got %0b want 01", port_accept); end
    tick();
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd0, 64'h0);
    tick();
  endtask

  task automatic test_full();
    drive(BUS_LOAD, BUS_NONE, 4'd1, 4'd0, 64'h0);
    tick();
    drive(BUS_LOAD, BUS_NONE, 4'd2, 4'd0, 64'h0);
    tick();
    drive(BUS_LOAD, BUS_NONE, 4'd3, 4'd0, 64'h0);
    #1;
    tests++; if (outstanding_count !== 4'd2) begin fails++; $display("FAIL full_count: got %0d want 2", outstanding_count); end
    tests++; if (proc2mem_command !== BUS_NONE || port_accept !== 2'b00) begin fails++; $display("FAIL full_hold: got cmd=%0d acc=%0b want 0 00", proc2mem_command, port_accept); end
    tick();
    drive(BUS_LOAD, BUS_NONE, 4'd3, 4'd1, 64'h11);
    #1;
    tests++; if (proc2mem_command !== BUS_NONE) begin fails++; $display("FAIL full_hold_ret: got %0d want 0", proc2mem_command); end
    tick();
    tests++; if (resp_valid !== 1'b1 || outstanding_count !== 4'd1) begin fails++; $display("FAIL full_free: got v=%0b cnt=%0d want 1 1", resp_valid, outstanding_count); end
    drive(BUS_LOAD, BUS_NONE, 4'd3, 4'd0, 64'h0);
    #1;
    tests++; if (proc2mem_command !== BUS_LOAD || port_accept !== 2'b01 || port_accept_tag !== 4'd3) begin fails++; $display("FAIL full_issue: got cmd=%0d acc=%0b tag=%0d want 1 01 3", proc2mem_command, port_accept, port_accept_tag); end
    tick();
    tests++; if (outstanding_count !== 4'd2) begin fails++; $display("FAIL full_refill: got %0d want 2", outstanding_count); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd2, 64'h22);
    tick();
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd3, 64'h33);
    tick();
    tests++; if (outstanding_count !== 4'd0 || resp_tag !== 4'd3 || resp_data !== 64'h33) begin fails++; $display("FAIL full_drain: got cnt=%0d t=%0d d=%0h want 0 3 33", outstanding_count, resp_tag, resp_data); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd0, 64'h0);
    tick();
  endtask

  task automatic test_unknown_tag();
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd5, 64'h55);
    tick();
    tests++; if (err_unknown_tag !== 1'b1 || resp_valid !== 1'b0 || resp_tag !== 4'd0) begin fails++; $display("FAIL unk_flag: got e=%0b v=%0b t=%0d want 1 0 0", err_unknown_tag, resp_valid, resp_tag); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd0, 64'h0);
    tick();
    tests++; if (err_unknown_tag !== 1'b0) begin fails++; $display("FAIL unk_pulse: got %0b want 0", err_unknown_tag); end
  endtask

  task automatic test_free_alloc();
    drive(BUS_LOAD, BUS_NONE, 4'd3, 4'd0, 64'h0);
    tick();
    drive(BUS_NONE, BUS_LOAD, 4'd3, 4'd3, 64'hC3);
    #1;
    tests++; if (port_accept !== 2'b10) begin fails++; $display("FAIL fa_accept: got %0b want 10", port_accept); end
    tick();
    tests++; if (resp_valid !== 1'b1 || resp_port !== 1'b0 || resp_data !== 64'hC3 || outstanding_count !== 4'd1) begin fails++; $display("FAIL fa_old: got v=%0b p=%0d d=%0h cnt=%0d want 1 0 c3 1", resp_valid, resp_port, resp_data, outstanding_count); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd3, 64'hD3);
    tick();
    tests++; if (resp_valid !== 1'b1 || resp_port !== 1'b1 || outstanding_count !== 4'd0) begin fails++; $display("FAIL fa_new: got v=%0b p=%0d cnt=%0d want 1 1 0", resp_valid, resp_port, outstanding_count); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd0, 64'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(BUS_LOAD, BUS_NONE, 4'd6, 4'd0, 64'h0);
    tick();
    drive(BUS_LOAD, BUS_NONE, 4'd7, 4'd0, 64'h0);
    tick();
    tests++; if (outstanding_count !== 4'd2) begin fails++; $display("FAIL rm_pre: got %0d want 2", outstanding_count); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd0, 64'h0);
    reset = 1'b0;
    tick();
    tests++; if (outstanding_count !== 4'd0 || resp_valid !== 1'b0 || resp_port !== 1'b0 || resp_data !== 64'h0 || err_unknown_tag !== 1'b0) begin fails++; $display("FAIL rm_clear: got cnt=%0d v=%0b p=%0d d=%0h e=%0b want all 0", outstanding_count, resp_valid, resp_port, resp_data, err_unknown_tag); end
    reset = 1'b1;
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd6, 64'h66);
    tick();
    tests++; if (err_unknown_tag !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL rm_stale: got e=%0b v=%0b want 1 0", err_unknown_tag, resp_valid); end
    drive(BUS_NONE, BUS_NONE, 4'd0, 4'd0, 64'h0);
    tick();
  endtask

  initial begin
    port_addr[0] = 32'h1000;
    port_addr[1] = 32'h2000;
    port_data[0] = 64'hD0;
    port_data[1] = 64'hD1;
    test_reset();
    test_two_loads();
    test_arbitration();
    test_refused();
    test_full();
    test_unknown_tag();
    test_free_alloc();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_n.md
MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesting caches (port 0 = dcache, port 1 = icache).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 8, in-flight memory transaction limit (1..15).
REQ-003 SHALL have ports: clock  in  1  single system clock, all logic on posedge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: port_command  in  NUM_PORTS x BUS_COMMAND  per-port request (BUS_NONE = idle).
REQ-006 SHALL have ports: port_addr  in  NUM_PORTS x XLEN  per-port address.
REQ-007 SHALL have ports: port_data  in  NUM_PORTS x 64  per-port store data.
REQ-008 SHALL have ports: port_accept  out  NUM_PORTS  one-hot, request accepted by memory this cycle.
REQ-009 SHALL have ports: port_accept_tag  out  4  memory tag for the accepted request.
REQ-010 SHALL have ports: proc2mem_command / proc2mem_addr / proc2mem_data  out  BUS_COMMAND / XLEN / 64  to memory.
REQ-011 SHALL have ports: mem2proc_response / mem2proc_data / mem2proc_tag  in  4 / 64 / 4  from memory; 0 = none.
REQ-012 SHALL have ports: resp_valid  out  1, resp_port  out  clog2(NUM_PORTS), resp_data  out  64, resp_tag  out  4  routed response.
REQ-013 SHALL have ports: outstanding_count  out  4, err_unknown_tag  out  1.

Function
REQ-014 SHALL select one requesting port per cycle combinationally and drive its command/addr/data to memory the same cycle.
REQ-015 SHALL drive proc2mem_command = BUS_NONE when no port requests or outstanding_count == MAX_OUTSTANDING (full).
REQ-016 SHALL treat a request as accepted only when mem2proc_response != 0 in the issuing cycle; port_accept and port_accept_tag are then asserted combinationally.
REQ-017 SHALL leave arbitration state unchanged on a refused issue (mem2proc_response == 0); the port holds its request.
REQ-018 SHALL, on accepted BUS_LOAD, record {valid, port} in a 15-entry tag table indexed by mem2proc_response and increment outstanding_count.
REQ-019 SHALL not allocate table entries for BUS_STORE; stores complete on acceptance.
REQ-020 SHALL, when mem2proc_tag != 0 hits a valid entry, register resp_valid=1, resp_port, resp_data=mem2proc_data, resp_tag next cycle (latency 1), clear the entry, decrement count.
REQ-021 SHALL, when mem2proc_tag != 0 hits an invalid entry, drop the data, keep resp_valid=0 and pulse err_unknown_tag for one cycle (registered).
REQ-022 SHALL, on same-cycle free and allocate, apply free before allocate (same tag ends valid with new port; count net unchanged).
REQ-023 SHALL hold resp_valid=0 and resp_tag=0 in any cycle without a routed response.
REQ-024 SHALL never let outstanding_count exceed MAX_OUTSTANDING nor underflow below 0.

Reset
REQ-025 SHALL, when reset==0 at posedge clock, clear all table valid bits, outstanding_count=0, round-robin pointer=0, resp_valid=0, resp_port=0, resp_data=0, resp_tag=0, err_unknown_tag=0.
REQ-026 SHALL discard in-flight transactions on reset mid-operation; later returns of those tags raise err_unknown_tag.
REQ-027 SHALL drive proc2mem_command=BUS_NONE during reset.

Configuration
REQ-028 SHALL support macro MEM_ARBITER_RR_EN: defined -> round-robin, pointer advances to one past the granted port on acceptance only.
REQ-029 SHALL, without MEM_ARBITER_RR_EN, use fixed priority, lowest index wins (dcache over icache).

Structure
REQ-030 SHALL take BUS_COMMAND, XLEN and a new MEM_TAG_ENTRY struct {valid, port} from the shared sys_defs package.
REQ-031 SHALL place arbitration in one sub-module rr_arbiter (request vector, advance strobe -> one-hot grant).

Verification
REQ-032 Ports 0,1 both BUS_LOAD, memory returns tags 1,2 -> port 0 accepted tag 1 first, port 1 tag 2 next cycle; both responses routed to correct resp_port.
REQ-033 RR build, both ports request continuously, 6 accepts -> grants alternate 0,1,0,1,0,1; non-RR build -> port 0 six times.
REQ-034 MAX_OUTSTANDING=2, three loads, no returns -> third held at BUS_NONE, count=2; after tag 1 returns, third issues next cycle.
REQ-035 mem2proc_tag=5 with no entry 5 -> resp_valid=0, err_unknown_tag=1 for one cycle.
REQ-036 Tag 3 returns in same cycle memory reassigns tag 3 to port 1 -> response to old port, entry 3 valid for port 1, count unchanged.
REQ-037 Reset asserted with 2 outstanding -> count=0, all outputs zero next cycle; stale tag return flags error.
